// File: rtl/escaneo_teclado.sv
// 4x4 keypad scanner/debouncer: rotates an active-low column, samples the
// synchronized rows, and emits one strobe plus a {row, col} code per press.
module escaneo_teclado #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] input_teclado,
  output logic       key_detect,
  output logic       ocupado
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYC);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e            state_q, state_d;
  logic [3:0]        filas_m, filas_s;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        columnas_q, columnas_d;
  logic [3:0]        code_q, code_d;
  logic              key_q, key_d;
  logic              ocup_q, ocup_d;
  logic [1:0]        low_row;
  logic              any_low;

  // Two-flop synchronizer for the asynchronous row lines (idle = pulled up).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filas_m <= 4'b1111;
      filas_s <= 4'b1111;
    end else begin
      filas_m <= filas;
      filas_s <= filas_m;
    end
  end

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    any_low = (filas_s != 4'b1111);
    if (!filas_s[0])      low_row = 2'd0;
    else if (!filas_s[1]) low_row = 2'd1;
    else if (!filas_s[2]) low_row = 2'd2;
    else                  low_row = 2'd3;
  end

  // State and all output registers; outputs never see filas combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StScan;
      dwell_q    <= '0;
      cnt_q      <= '0;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      columnas_q <= 4'b1110;
      code_q     <= 4'b0000;
      key_q      <= 1'b0;
      ocup_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      columnas_q <= columnas_d;
      code_q     <= code_d;
      key_q      <= key_d;
      ocup_q     <= ocup_d;
    end
  end

  // Next-state logic; counters only advance below their terminal value.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    code_d  = code_q;
    key_d   = 1'b0;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (any_low) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StDebounce: begin
        if (filas_s[row_q]) begin
          // Bounce or glitch: abandon this key and move on to the next column.
          state_d = StScan;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (cnt_q == CntLast) begin
          key_d   = 1'b1;
          code_d  = {row_q, col_q};
          cnt_d   = '0;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!any_low) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (any_low) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d = StScan;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
    columnas_d = ~(4'b0001 << col_d);
    ocup_d     = (state_d != StScan);
  end

  assign columnas      = columnas_q;
  assign input_teclado = code_q;
  assign key_detect    = key_q;
  assign ocupado       = ocup_q;

endmodule
